// File: rtl/riscv_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state
// encodings, the buffered {pc, instr} entry and PC helpers.
package riscv_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE      = 2'd0,
        FETCH_WAIT      = 2'd1,
        FETCH_WAIT_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Redirect targets may carry low bits; fetch addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Fetch unit bundle: instruction memory request/response, instruction
// output towards the core, and the redirect input.
interface riscv_fetch_unit_if;

    // valid/ready: a transfer happens on a rising edge where both are high;
    // imem_req_valid may be withdrawn only in a redirect cycle.
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries; flush wins over push and pop.
module riscv_fetch_fifo
    import riscv_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: single-outstanding word reads, small {pc, instr}
// buffer towards the core, redirect flushes buffered and in-flight fetches.
module riscv_fetch_unit
    import riscv_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    riscv_fetch_unit_if.master        fetch_if,
    output fetch_state_e              dbg_state_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;

    logic          req_valid;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    riscv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (fetch_if.redirect_valid),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        req_valid  = (state_q == FETCH_IDLE) && !fifo_full &&
                     !fetch_if.redirect_valid && !rst;
        req_fire   = req_valid && fetch_if.imem_req_ready;
        push       = (state_q == FETCH_WAIT) && fetch_if.imem_rsp_valid &&
                     !fetch_if.redirect_valid;
        pop        = (fifo_count != '0) && fetch_if.instr_ready;
        push_entry = '{pc: inflight_pc_q, instr: fetch_if.imem_rsp_data};
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;

        case (state_q)
            FETCH_IDLE: begin
                if (req_fire) begin
                    state_d       = FETCH_WAIT;
                    fetch_pc_d    = fetch_pc_q + PC_INCR;
                    inflight_pc_d = fetch_pc_q;
                end
            end
            FETCH_WAIT, FETCH_WAIT_DROP: begin
                if (fetch_if.imem_rsp_valid) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase

        // The outstanding response, if still to come, belongs to the old path.
        if (fetch_if.redirect_valid) begin
            fetch_pc_d = align_pc(fetch_if.redirect_pc);
            if (state_q != FETCH_IDLE && !fetch_if.imem_rsp_valid) begin
                state_d = FETCH_WAIT_DROP;
            end else begin
                state_d = FETCH_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH_IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign fetch_if.imem_req_valid = req_valid;
    assign fetch_if.imem_addr      = fetch_pc_q;
    assign fetch_if.instr_valid    = (fifo_count != '0);
    assign fetch_if.instr          = fifo_empty ? 32'h0 : head.instr;
    assign fetch_if.instr_pc       = fifo_empty ? 32'h0 : head.pc;
    assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: reset, streaming, back-pressure,
// redirects (outstanding, same-cycle response, wrap) and mid-request reset.
module tb_riscv_fetch_unit;
    import riscv_fetch_unit_pkg::*;

    logic         clk;
    logic         rst;
    fetch_state_e dbg_state;
    bit           mem_auto;
    int           n_cmp;
    int           n_err;

    riscv_fetch_unit_if ifc ();

    riscv_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_if    (ifc.master),
        .dbg_state_o (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock; in auto mode memory answers one cycle after each accepted
    // request with addr ^ 0x13.
    task automatic tick();
        logic        fire;
        logic [31:0] addr;
        @(negedge clk);
        fire = ifc.imem_req_valid && ifc.imem_req_ready;
        addr = ifc.imem_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            ifc.imem_rsp_valid = fire;
            ifc.imem_rsp_data  = fire ? (addr ^ 32'h13) : 32'h0;
        end
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mem_auto = 1'b1;
        rst = 1'b1;
        ifc.imem_req_ready = 1'b1;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = 32'h0;
        ifc.instr_ready    = 1'b1;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        chk("rst_addr", ifc.imem_addr, 32'h0);
        chk("rst_instr_valid", 32'(ifc.instr_valid), 32'd0);
        chk("rst_instr", ifc.instr, 32'h0);
        chk("rst_instr_pc", ifc.instr_pc, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(FETCH_IDLE));

        // Streaming: issue, response, then the entry is visible (3rd cycle)
        rst = 1'b0;
        #1;
        chk("s_req_valid0", 32'(ifc.imem_req_valid), 32'd1);
        chk("s_addr0", ifc.imem_addr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s_gap_valid", 32'(ifc.instr_valid), 32'd0);
            chk("s_gap_state", 32'(dbg_state), 32'(FETCH_WAIT));
            tick();
            chk("s_valid", 32'(ifc.instr_valid), 32'd1);
            chk("s_pc", ifc.instr_pc, 32'(4 * k));
            chk("s_instr", ifc.instr, 32'(4 * k) ^ 32'h13);
        end

        // Back-pressure: buffer fills with pc 0,4 then requests stop
        ifc.instr_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_valid", 32'(ifc.instr_valid), 32'd1);
        chk("bp_pc", ifc.instr_pc, 32'h0);
        chk("bp_instr", ifc.instr, 32'h13);
        chk("bp_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        chk("bp_state", 32'(dbg_state), 32'(FETCH_IDLE));
        ifc.instr_ready = 1'b1;
        #1;
        chk("bp_head0", ifc.instr_pc, 32'h0);
        tick();
        chk("bp_head1", ifc.instr_pc, 32'h4);
        chk("bp_instr1", ifc.instr, 32'h17);
        chk("bp_req_after", 32'(ifc.imem_req_valid), 32'd1);
        chk("bp_addr_after", ifc.imem_addr, 32'h8);
        tick();
        chk("bp_empty", 32'(ifc.instr_valid), 32'd0);
        tick();
        chk("bp_head2", ifc.instr_pc, 32'h8);
        chk("bp_instr2", ifc.instr, 32'h1b);

        // Redirect to 0x100 while the request for pc 12 is outstanding
        mem_auto = 1'b0;
        tick();
        chk("r1_state_wait", 32'(dbg_state), 32'(FETCH_WAIT));
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h100;
        tick();
        ifc.redirect_valid = 1'b0;
        #1;
        chk("r1_state_drop", 32'(dbg_state), 32'(FETCH_WAIT_DROP));
        chk("r1_req_valid", 32'(ifc.imem_req_valid), 32'd0);
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        ifc.imem_rsp_valid = 1'b0;
        #1;
        chk("r1_state_idle", 32'(dbg_state), 32'(FETCH_IDLE));
        chk("r1_no_stale", 32'(ifc.instr_valid), 32'd0);
        chk("r1_req_valid2", 32'(ifc.imem_req_valid), 32'd1);
        chk("r1_addr", ifc.imem_addr, 32'h100);
        mem_auto = 1'b1;
        tick();
        tick();
        chk("r1_pc", ifc.instr_pc, 32'h100);
        chk("r1_instr", ifc.instr, 32'h113);

        // Redirect in the same cycle as the response, unaligned target
        tick();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h203;
        tick();
        ifc.redirect_valid = 1'b0;
        #1;
        chk("r2_state", 32'(dbg_state), 32'(FETCH_IDLE));
        chk("r2_dropped", 32'(ifc.instr_valid), 32'd0);
        chk("r2_req_valid", 32'(ifc.imem_req_valid), 32'd1);
        chk("r2_addr", ifc.imem_addr, 32'h200);
        tick();
        tick();
        chk("r2_pc", ifc.instr_pc, 32'h200);
        chk("r2_instr", ifc.instr, 32'h213);

        // Memory stalls: request held with a stable address
        ifc.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_req_valid", 32'(ifc.imem_req_valid), 32'd1);
            chk("st_addr", ifc.imem_addr, 32'h204);
        end
        chk("st_state", 32'(dbg_state), 32'(FETCH_IDLE));

        // Reset while waiting; the late response must be ignored
        ifc.imem_req_ready = 1'b1;
        mem_auto = 1'b0;
        tick();
        chk("mr_state_wait", 32'(dbg_state), 32'(FETCH_WAIT));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'h0000_0BAD;
        #1;
        chk("mr_state_idle", 32'(dbg_state), 32'(FETCH_IDLE));
        chk("mr_req_valid", 32'(ifc.imem_req_valid), 32'd1);
        chk("mr_addr", ifc.imem_addr, 32'h0);
        tick();
        ifc.imem_rsp_data = 32'h13;
        chk("mr_late_ignored", 32'(ifc.instr_valid), 32'd0);
        chk("mr_state_wait2", 32'(dbg_state), 32'(FETCH_WAIT));
        tick();
        ifc.imem_rsp_valid = 1'b0;
        chk("mr_pc", ifc.instr_pc, 32'h0);
        chk("mr_instr", ifc.instr, 32'h13);

        // Redirect to the top word, then the fetch address wraps to zero
        mem_auto = 1'b1;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk("w_req_suppressed", 32'(ifc.imem_req_valid), 32'd0);
        tick();
        ifc.redirect_valid = 1'b0;
        #1;
        chk("w_flushed", 32'(ifc.instr_valid), 32'd0);
        chk("w_addr_top", ifc.imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("w_pc_top", ifc.instr_pc, 32'hFFFF_FFFC);
        chk("w_instr_top", ifc.instr, 32'hFFFF_FFEF);
        chk("w_addr_wrap", ifc.imem_addr, 32'h0);
        tick();
        tick();
        chk("w_pc_wrap", ifc.instr_pc, 32'h0);
        chk("w_instr_wrap", ifc.instr, 32'h13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
- Instruction fetch stage directly upstream of riscv_simple; produces the instr word the core consumes.
- Holds the fetch PC and issues single-outstanding word reads to instruction memory.
- Buffers returned words with their PC in a small FIFO and presents them to the core over a valid/ready handshake.
- Accepts a redirect (taken branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  32  word-aligned fetch address, bits [1:0] always 0.
- imem_rsp_valid  input  1  read data valid; one response per accepted request, in order, at least 1 cycle after accept.
- imem_rsp_data  input  32  instruction word.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  core consumes head.
- instr  output  32  head instruction.
- instr_pc  output  32  PC of head instruction.
- redirect_valid  input  1  redirect request, single-cycle pulse.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (treated as 0).

Behaviour:
- Reset (rst=1 at clk edge): fetch_pc=RESET_PC, FIFO empty, state IDLE, drop flag 0. Outputs: imem_req_valid=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Reset mid-operation abandons any outstanding request. Any response arriving in the first cycle after reset is ignored (state IDLE).
- States:
  - IDLE: no request outstanding.
  - WAIT: one outstanding request; its response is kept.
  - WAIT_DROP: one outstanding request; its response is discarded.
- imem_req_valid = (state==IDLE) && (count < FIFO_DEPTH) && !redirect_valid. imem_addr = fetch_pc.
- IDLE -> WAIT on req handshake (valid && ready). Same edge: fetch_pc += 4; 32-bit wrap 0xFFFF_FFFC -> 0x0000_0000.
- WAIT -> IDLE on imem_rsp_valid. Pushes {pc, data}, where pc is the accepted address, held in an inflight_pc register.
- WAIT_DROP -> IDLE on imem_rsp_valid. Nothing pushed.
- Redirect (highest priority, same edge):
  - FIFO flushed to count=0.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - WAIT goes to WAIT_DROP.
  - A response arriving in the redirect cycle is discarded; state goes to IDLE.
  - A FIFO pop in the redirect cycle is harmless; the core owns squash of that instruction.
  - The request is suppressed in the redirect cycle. The new request is visible at earliest the next cycle.
- Redirect while in WAIT_DROP stays in WAIT_DROP and updates fetch_pc.
- Push and pop in the same cycle with FIFO full are not possible, because no request issues when full. Simultaneous push+pop otherwise leaves count unchanged.
- Space is checked at issue time only; single-outstanding guarantees the push fits.
- instr_valid = count!=0. instr/instr_pc come from the head, held stable while instr_valid && !instr_ready.
- Latency: with memory ready and 1-cycle response, first instr_valid occurs 3 cycles after rst deasserts (issue, response, registered push).
- Steady-state throughput: 1 instruction per 2 cycles (single outstanding).
- imem_addr is held stable while imem_req_valid && !imem_req_ready, except in a redirect cycle, where the request is withdrawn. The memory must tolerate a withdrawn request.

Decomposition:
- defines.v (shared): FETCH_IDLE, FETCH_WAIT, FETCH_WAIT_DROP state encodings (2 bits); `PC_INCR 32'd4.
- One sub-module: riscv_fetch_fifo, synchronous FIFO, 64-bit entries {pc,instr}, parameter DEPTH, ports push/pop/flush/full/empty/count. Flush has priority over push and pop.
- Top level holds the FSM, fetch_pc and inflight_pc.

Test Plan:
- Reset, then memory always ready with 1-cycle response returning addr^0x13 (ADDI-like), instr_ready=1 -> instr_pc sequence 0,4,8,12, each instr matching its data, first valid 3 cycles after reset release.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=2 entries buffered (pc 0,4), then imem_req_valid=0. Release -> 0,4,8 in order, no loss or duplicate.
- Redirect to 0x100 while a request is outstanding -> stale response dropped, next request addr 0x100, next instr_pc 0x100, no pc-4 entry emitted.
- Redirect in the same cycle as imem_rsp_valid, redirect_pc=0x203 -> response discarded, next imem_addr 0x200.
- imem_req_ready low for 5 cycles -> imem_addr stable at the same value, fetch_pc not advanced; rst asserted mid-WAIT -> next request addr RESET_PC, late response ignored.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000 (wrap).
